// File: rtl/cmp_operand_stager_if.sv
// Operand-in / result-out handshake bundle plus the comparator netlist bus for cmp_operand_stager.
interface cmp_operand_stager_if #(
    parameter int unsigned SEQ_W = 8
);
    logic             in_valid;
    logic             in_ready;
    logic [31:0]      in_data;
    logic [63:0]      cmp_x;
    logic             cmp_y;
    logic             out_valid;
    logic             out_ready;
    logic             out_lteq;
    logic [SEQ_W-1:0] out_seq;

    // Environment side: supplies operands, drives the netlist result, consumes results
    modport master (
        output in_valid, in_data, out_ready, cmp_y,
        input  in_ready, cmp_x, out_valid, out_lteq, out_seq
    );

    // Stager side
    modport slave (
        input  in_valid, in_data, out_ready, cmp_y,
        output in_ready, cmp_x, out_valid, out_lteq, out_seq
    );
endinterface

// File: rtl/cmp_operand_stager.sv
// Sequential front-end for the flat 32-bit signed <= comparator netlist.
// Collects a then b from a word stream, holds {b,a} on cmp_x for SETTLE_CYCLES,
// samples cmp_y and hands the result downstream with a wrapping sequence tag.
// Optional macro CMP_SELF_CHECK_EN adds a sticky chk_err output that flags any
// disagreement between cmp_y and a behavioural signed compare of the held pair.
module cmp_operand_stager #(
    parameter int unsigned SETTLE_CYCLES = 1,
    parameter int unsigned SEQ_W         = 8
) (
    input  logic                    clk,
    input  logic                    rst_n,
    cmp_operand_stager_if.slave     bus
`ifdef CMP_SELF_CHECK_EN
    ,
    output logic                    chk_err
`endif
);
    localparam int unsigned DATA_W = 32;
    localparam int unsigned CNT_W  = 4;
    localparam int unsigned X_W    = 2 * DATA_W;

    typedef enum logic [1:0] {
        S_A    = 2'd0,
        S_B    = 2'd1,
        S_EVAL = 2'd2,
        S_HOLD = 2'd3
    } state_e;

    state_e              state_q, state_d;
    logic [DATA_W-1:0]   a_q, a_d;
    logic [X_W-1:0]      cmp_x_q, cmp_x_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic                out_valid_q, out_valid_d;
    logic                out_lteq_q, out_lteq_d;
    logic [SEQ_W-1:0]    out_seq_q, out_seq_d;
    logic                in_ready_c;
    logic                settle_done_c;
`ifdef CMP_SELF_CHECK_EN
    logic                chk_err_q, chk_err_d;
    logic                ref_lteq_c;
`endif

    assign settle_done_c = (cnt_q == CNT_W'(SETTLE_CYCLES - 1));

`ifdef CMP_SELF_CHECK_EN
    // Behavioural reference on the pair currently presented to the netlist
    assign ref_lteq_c = ($signed(cmp_x_q[DATA_W-1:0]) <= $signed(cmp_x_q[X_W-1:DATA_W]));
`endif

    // Next-state and datapath updates; in_ready depends only on state and reset
    always_comb begin
        state_d     = state_q;
        a_d         = a_q;
        cmp_x_d     = cmp_x_q;
        cnt_d       = cnt_q;
        out_valid_d = out_valid_q;
        out_lteq_d  = out_lteq_q;
        out_seq_d   = out_seq_q;
        in_ready_c  = 1'b0;
`ifdef CMP_SELF_CHECK_EN
        chk_err_d   = chk_err_q;
`endif
        case (state_q)
            S_A: begin
                in_ready_c = rst_n;
                if (bus.in_valid) begin
                    a_d     = bus.in_data;
                    state_d = S_B;
                end
            end
            S_B: begin
                in_ready_c = rst_n;
                if (bus.in_valid) begin
                    // a and b become visible together so cmp_x never shows a mixed pair
                    cmp_x_d = {bus.in_data, a_q};
                    cnt_d   = '0;
                    state_d = S_EVAL;
                end
            end
            S_EVAL: begin
                cnt_d = cnt_q + CNT_W'(1);
                if (settle_done_c) begin
                    out_lteq_d  = bus.cmp_y;
                    out_valid_d = 1'b1;
                    state_d     = S_HOLD;
`ifdef CMP_SELF_CHECK_EN
                    if (bus.cmp_y != ref_lteq_c) begin
                        chk_err_d = 1'b1;
                    end
`endif
                end
            end
            S_HOLD: begin
                if (bus.out_ready) begin
                    out_valid_d = 1'b0;
                    out_seq_d   = out_seq_q + SEQ_W'(1);
                    state_d     = S_A;
                end
            end
            default: begin
                state_d = S_A;
            end
        endcase
    end

    // State and datapath registers with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= S_A;
            a_q         <= '0;
            cmp_x_q     <= '0;
            cnt_q       <= '0;
            out_valid_q <= 1'b0;
            out_lteq_q  <= 1'b0;
            out_seq_q   <= '0;
`ifdef CMP_SELF_CHECK_EN
            chk_err_q   <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            a_q         <= a_d;
            cmp_x_q     <= cmp_x_d;
            cnt_q       <= cnt_d;
            out_valid_q <= out_valid_d;
            out_lteq_q  <= out_lteq_d;
            out_seq_q   <= out_seq_d;
`ifdef CMP_SELF_CHECK_EN
            chk_err_q   <= chk_err_d;
`endif
        end
    end

    assign bus.in_ready  = in_ready_c;
    assign bus.cmp_x     = cmp_x_q;
    assign bus.out_valid = out_valid_q;
    assign bus.out_lteq  = out_lteq_q;
    assign bus.out_seq   = out_seq_q;
`ifdef CMP_SELF_CHECK_EN
    assign chk_err       = chk_err_q;
`endif
endmodule

// File: tb/tb_cmp_operand_stager.sv
// Bench for cmp_operand_stager: two instances (SETTLE=1/SEQ_W=8 and SETTLE=4/SEQ_W=2)
// driven through a selector, with a behavioural comparator netlist and a
// transaction-level model of expected results, latency and tags.
module tb_cmp_operand_stager;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    logic        sel = 1'b0;
    logic        in_valid = 1'b0;
    logic [31:0] in_data = '0;
    logic        out_ready = 1'b0;
    logic        force_y = 1'b0;
    logic        force_val = 1'b0;

    cmp_operand_stager_if #(.SEQ_W(8)) ifa ();
    cmp_operand_stager_if #(.SEQ_W(2)) ifb ();

    assign ifa.in_valid  = in_valid & ~sel;
    assign ifb.in_valid  = in_valid & sel;
    assign ifa.in_data   = in_data;
    assign ifb.in_data   = in_data;
    assign ifa.out_ready = out_ready & ~sel;
    assign ifb.out_ready = out_ready & sel;
    assign ifa.cmp_y = force_y ? force_val : ($signed(ifa.cmp_x[31:0]) <= $signed(ifa.cmp_x[63:32]));
    assign ifb.cmp_y = force_y ? force_val : ($signed(ifb.cmp_x[31:0]) <= $signed(ifb.cmp_x[63:32]));

`ifdef CMP_SELF_CHECK_EN
    logic chk_err_a, chk_err_b;
`endif

    cmp_operand_stager #(.SETTLE_CYCLES(1), .SEQ_W(8)) u_dut_a (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (ifa)
`ifdef CMP_SELF_CHECK_EN
        , .chk_err (chk_err_a)
`endif
    );

    cmp_operand_stager #(.SETTLE_CYCLES(4), .SEQ_W(2)) u_dut_b (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (ifb)
`ifdef CMP_SELF_CHECK_EN
        , .chk_err (chk_err_b)
`endif
    );

    logic        obs_in_ready, obs_out_valid, obs_out_lteq;
    logic [7:0]  obs_out_seq;
    logic [63:0] obs_cmp_x;
    always_comb begin
        obs_in_ready  = sel ? ifb.in_ready  : ifa.in_ready;
        obs_out_valid = sel ? ifb.out_valid : ifa.out_valid;
        obs_out_lteq  = sel ? ifb.out_lteq  : ifa.out_lteq;
        obs_out_seq   = sel ? {6'b0, ifb.out_seq} : ifa.out_seq;
        obs_cmp_x     = sel ? ifb.cmp_x     : ifa.cmp_x;
    end

    // Reference model state: results completed per instance since last reset
    int exp_count [2];
    int settle_of [2];
    int seq_mod   [2];

    function automatic logic ref_lteq(input logic [31:0] a, input logic [31:0] b);
        int sa, sb;
        sa = int'(a);
        sb = int'(b);
        return (sa <= sb);
    endfunction

    function automatic logic [7:0] ref_seq(input int s);
        return 8'(exp_count[s] % seq_mod[s]);
    endfunction

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        exp_count[0] = 0;
        exp_count[1] = 0;
    endtask

    // Drive one a/b pair on the selected instance and collect what it returned
    task automatic run_pair(input logic [31:0] a, input logic [31:0] b, input int stall,
                            input bit early_ready, input bit junk,
                            output logic lteq, output logic [7:0] seq, output int lat,
                            output logic [63:0] cx, output bit stable, output bit rdy_low,
                            output bit dropped, output bit tmo);
        int n;
        tmo = 1'b0; stable = 1'b1; rdy_low = 1'b1;
        @(negedge clk);
        in_valid = 1'b1; in_data = a; out_ready = early_ready;
        n = 0;
        while (!obs_in_ready && n < 100) begin @(negedge clk); n++; end
        if (!obs_in_ready) tmo = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_data = b;
        if (!obs_in_ready) tmo = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid = junk; in_data = $urandom();
        lat = 0;
        while (!obs_out_valid && lat < 100) begin
            if (obs_in_ready) rdy_low = 1'b0;
            @(posedge clk); lat++; @(negedge clk);
        end
        if (!obs_out_valid) tmo = 1'b1;
        if (obs_in_ready) rdy_low = 1'b0;
        lteq = obs_out_lteq; seq = obs_out_seq; cx = obs_cmp_x;
        if (!early_ready) begin
            for (int i = 0; i < stall; i++) begin
                @(posedge clk); @(negedge clk);
                in_data = $urandom();
                if (!obs_out_valid || obs_out_lteq !== lteq || obs_out_seq !== seq || obs_cmp_x !== cx)
                    stable = 1'b0;
                if (obs_in_ready) rdy_low = 1'b0;
            end
            out_ready = 1'b1;
        end
        @(posedge clk);
        @(negedge clk);
        dropped = !obs_out_valid;
        out_ready = 1'b0; in_valid = 1'b0;
    endtask

    // Run a pair and compare every observable against the model
    task automatic check_pair(input string tag, input logic [31:0] a, input logic [31:0] b,
                              input int stall, input bit early_ready, input bit junk);
        logic lteq; logic [7:0] seq; int lat; logic [63:0] cx;
        bit stable, rdy_low, dropped, tmo;
        logic       e_lteq;
        logic [7:0] e_seq;
        e_lteq = ref_lteq(a, b);
        e_seq  = ref_seq(sel);
        run_pair(a, b, stall, early_ready, junk, lteq, seq, lat, cx, stable, rdy_low, dropped, tmo);
        exp_count[sel]++;
        checks++;
        if (tmo !== 1'b0) begin errors++; $display("FAIL %s timeout got=%0b want=0", tag, tmo); end
        checks++;
        if (lteq !== e_lteq) begin errors++; $display("FAIL %s lteq a=%h b=%h got=%0b want=%0b", tag, a, b, lteq, e_lteq); end
        checks++;
        if (seq !== e_seq) begin errors++; $display("FAIL %s seq got=%0d want=%0d", tag, seq, e_seq); end
        checks++;
        if (lat !== settle_of[sel]) begin errors++; $display("FAIL %s latency got=%0d want=%0d", tag, lat, settle_of[sel]); end
        checks++;
        if (cx !== {b, a}) begin errors++; $display("FAIL %s cmp_x got=%h want=%h", tag, cx, {b, a}); end
        checks++;
        if (stable !== 1'b1) begin errors++; $display("FAIL %s hold_stable got=%0b want=1", tag, stable); end
        checks++;
        if (rdy_low !== 1'b1) begin errors++; $display("FAIL %s in_ready_low got=%0b want=1", tag, rdy_low); end
        checks++;
        if (dropped !== 1'b1) begin errors++; $display("FAIL %s result_taken got=%0b want=1", tag, dropped); end
    endtask

    task automatic test_reset();
        @(negedge clk);
        rst_n = 1'b0;
        @(posedge clk);
        @(negedge clk);
        checks++;
        if (ifa.in_ready !== 1'b0 || ifb.in_ready !== 1'b0) begin
            errors++; $display("FAIL reset_in_ready got=%0b%0b want=00", ifa.in_ready, ifb.in_ready);
        end
        checks++;
        if (ifa.out_valid !== 1'b0 || ifb.out_valid !== 1'b0) begin
            errors++; $display("FAIL reset_out_valid got=%0b%0b want=00", ifa.out_valid, ifb.out_valid);
        end
        checks++;
        if (ifa.cmp_x !== 64'd0 || ifb.cmp_x !== 64'd0) begin
            errors++; $display("FAIL reset_cmp_x got=%h/%h want=0", ifa.cmp_x, ifb.cmp_x);
        end
        checks++;
        if (ifa.out_seq !== 8'd0 || ifb.out_seq !== 2'd0 || ifa.out_lteq !== 1'b0) begin
            errors++; $display("FAIL reset_seq_lteq got=%0d/%0d/%0b want=0/0/0", ifa.out_seq, ifb.out_seq, ifa.out_lteq);
        end
        rst_n = 1'b1;
        exp_count[0] = 0;
        exp_count[1] = 0;
        @(negedge clk);
        checks++;
        if (ifa.in_ready !== 1'b1 || ifb.in_ready !== 1'b1) begin
            errors++; $display("FAIL post_reset_in_ready got=%0b%0b want=11", ifa.in_ready, ifb.in_ready);
        end
    endtask

    task automatic test_directed();
        sel = 1'b0;
        check_pair("neg1_vs_0", 32'hFFFF_FFFF, 32'h0000_0000, 0, 1'b0, 1'b0);
        check_pair("max_vs_min", 32'h7FFF_FFFF, 32'h8000_0000, 0, 1'b0, 1'b0);
        check_pair("equal", 32'h1234_5678, 32'h1234_5678, 0, 1'b0, 1'b0);
    endtask

    task automatic test_random();
        logic [31:0] edge_vals [6];
        logic [31:0] a, b;
        edge_vals[0] = 32'h0000_0000; edge_vals[1] = 32'h0000_0001;
        edge_vals[2] = 32'hFFFF_FFFF; edge_vals[3] = 32'h7FFF_FFFF;
        edge_vals[4] = 32'h8000_0000; edge_vals[5] = 32'h8000_0001;
        for (int i = 0; i < 40; i++) begin
            sel = (i >= 28);
            a = ($urandom_range(3) == 0) ? edge_vals[$urandom_range(5)] : $urandom();
            b = ($urandom_range(3) == 0) ? edge_vals[$urandom_range(5)] : $urandom();
            if ($urandom_range(7) == 0) b = a;
            check_pair("random", a, b, int'($urandom_range(3)), 1'($urandom_range(1)), 1'($urandom_range(1)));
        end
        sel = 1'b0;
    endtask

    task automatic test_stall();
        sel = 1'b1;
        check_pair("settle4_stall5", 32'h8000_0000, 32'h7FFF_FFFF, 5, 1'b0, 1'b1);
        sel = 1'b0;
    endtask

    task automatic test_seq_wrap();
        do_reset();
        sel = 1'b1;
        for (int i = 0; i < 5; i++) begin
            check_pair("seq_wrap", $urandom(), $urandom(), 0, 1'b1, 1'b0);
        end
        sel = 1'b0;
    endtask

    task automatic test_reset_abort();
        int seen;
        sel = 1'b1;
        @(negedge clk);
        in_valid = 1'b1; in_data = 32'h0000_0003;
        @(posedge clk);
        @(negedge clk);
        in_data = 32'h0000_0009;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0; out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        @(posedge clk);
        @(negedge clk);
        exp_count[0] = 0;
        exp_count[1] = 0;
        checks++;
        if (obs_out_valid !== 1'b0 || obs_cmp_x !== 64'd0 || obs_out_seq !== 8'd0) begin
            errors++; $display("FAIL abort_reset got v=%0b x=%h s=%0d want v=0 x=0 s=0", obs_out_valid, obs_cmp_x, obs_out_seq);
        end
        rst_n = 1'b1;
        #1;
        checks++;
        if (obs_in_ready !== 1'b1) begin
            errors++; $display("FAIL abort_in_ready got=%0b want=1", obs_in_ready);
        end
        seen = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (obs_out_valid) seen++;
        end
        out_ready = 1'b0;
        checks++;
        if (seen !== 0) begin
            errors++; $display("FAIL abort_no_result got=%0d want=0", seen);
        end
        check_pair("after_abort", 32'hFFFF_FFF0, 32'hFFFF_FFF0, 0, 1'b0, 1'b0);
        sel = 1'b0;
    endtask

`ifdef CMP_SELF_CHECK_EN
    task automatic test_self_check();
        logic lteq; logic [7:0] seq; int lat; logic [63:0] cx;
        bit stable, rdy_low, dropped, tmo;
        do_reset();
        sel = 1'b0;
        checks++;
        if (chk_err_a !== 1'b0) begin errors++; $display("FAIL chk_err_reset got=%0b want=0", chk_err_a); end
        force_y = 1'b1; force_val = 1'b0;
        run_pair(32'h5, 32'h5, 0, 1'b0, 1'b0, lteq, seq, lat, cx, stable, rdy_low, dropped, tmo);
        force_y = 1'b0;
        checks++;
        if (chk_err_a !== 1'b1) begin errors++; $display("FAIL chk_err_set got=%0b want=1", chk_err_a); end
        check_pair("chk_sticky", 32'h1, 32'h2, 0, 1'b0, 1'b0);
        check_pair("chk_sticky", 32'h2, 32'h1, 0, 1'b0, 1'b0);
        checks++;
        if (chk_err_a !== 1'b1 || chk_err_b !== 1'b0) begin
            errors++; $display("FAIL chk_err_sticky got=%0b/%0b want=1/0", chk_err_a, chk_err_b);
        end
        do_reset();
        checks++;
        if (chk_err_a !== 1'b0) begin errors++; $display("FAIL chk_err_clear got=%0b want=0", chk_err_a); end
    endtask
`endif

    initial begin
        settle_of[0] = 1; settle_of[1] = 4;
        seq_mod[0] = 256; seq_mod[1] = 4;
        exp_count[0] = 0; exp_count[1] = 0;
        test_reset();
        test_directed();
        test_stall();
        test_random();
        test_seq_wrap();
        test_reset_abort();
`ifdef CMP_SELF_CHECK_EN
        test_self_check();
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    // Absolute time limit so the run always ends
    initial begin
        #500000;
        $display("FAIL global_timeout got=running want=finished");
        $fatal(1, "time limit");
    end
endmodule

// File: doc/cmp_operand_stager.md
Name: cmp_operand_stager

Overview:
- Sequential front-end for the flat 32-bit signed less-than-or-equal comparator netlist.
- Accepts operands as a 32-bit word stream over valid/ready: word 0 = a, word 1 = b.
- Packs both operands onto the comparator's 64-bit input bus and holds it stable while the netlist settles.
- Samples the 1-bit lteq result and presents it downstream over valid/ready with a sequence tag.

Parameters:
- SETTLE_CYCLES, 1, number of cycles the comparator input bus is held before cmp_y is sampled; legal range 1..15.
- SEQ_W, 8, width of the result sequence tag; the tag wraps modulo 2^SEQ_W.

Ports:
- clk  input  1  single clock; all state updates on the rising edge.
- rst_n  input  1  synchronous, active-low reset.
- in_valid  input  1  operand word valid.
- in_ready  output  1  stager can accept an operand word.
- in_data  input  32  operand word, two's complement.
- cmp_x  output  64  comparator input bus; bit i = a[i] for i=0..31, bit 32+i = b[i].
- cmp_y  input  1  comparator output; 1 means $signed(a) <= $signed(b).
- out_valid  output  1  result valid.
- out_ready  input  1  downstream accepts the result.
- out_lteq  output  1  sampled comparison result.
- out_seq  output  SEQ_W  sequence tag of the result.

Behaviour:
- Reset:
  - Applies on a clk edge with rst_n=0; overrides every other event, including a reset during any state.
  - Next state is S_A. cmp_x=0, out_valid=0, out_lteq=0, out_seq=0, settle counter=0.
  - in_ready is forced to 0 while rst_n=0.
- States: S_A, S_B, S_EVAL, S_HOLD.
- S_A:
  - in_ready=1.
  - On in_valid&in_ready: a_reg<=in_data, go to S_B.
- S_B:
  - in_ready=1.
  - On handshake: b_reg<=in_data, settle counter<=0, go to S_EVAL.
- S_EVAL:
  - in_ready=0.
  - Counter increments each cycle.
  - On the edge where counter==SETTLE_CYCLES-1: out_lteq<=cmp_y, out_valid<=1, go to S_HOLD.
- S_HOLD:
  - in_ready=0. out_valid=1; out_lteq and out_seq stable.
  - On out_valid&out_ready: out_valid<=0, out_seq<=out_seq+1 (wraps from 2^SEQ_W-1 to 0), go to S_A.
- Latency: out_valid rises exactly SETTLE_CYCLES edges after the b handshake edge.
- Minimum accept-to-accept period: SETTLE_CYCLES+3 cycles.
- cmp_x is driven only from a_reg/b_reg. It is constant from the b handshake until the next b handshake, so it never glitches during S_EVAL or S_HOLD.
- In S_A and S_B, cmp_x still shows the previous operands. The a_reg update is not visible on cmp_x until b is captured, so cmp_x always holds a coherent pair.
- out_ready asserted outside S_HOLD: ignored.
- in_valid asserted in S_EVAL/S_HOLD: ignored, no data consumed.
- in_data and cmp_y are don't-care when not being sampled.
- No combinational path from in_valid to in_ready, or from out_ready to out_valid.

Optional Feature:
- Macro: CMP_SELF_CHECK_EN.
- When defined:
  - Adds output port chk_err (1 bit, reset 0).
  - At the cmp_y sampling edge, the block computes $signed(a_reg) <= $signed(b_reg) behaviourally.
  - On mismatch with cmp_y, chk_err<=1. chk_err is sticky until reset.
  - Purpose: in-system equivalence monitor for optimized comparator netlists.
- When undefined: the port and the logic are absent; all other behaviour is identical.

Test Plan:
- a=0xFFFFFFFF (-1), b=0x00000000, netlist attached, SETTLE_CYCLES=1 -> out_valid one edge after b handshake; out_lteq=1; out_seq=0.
- a=0x7FFFFFFF, b=0x80000000 -> out_lteq=0; a=b=0x12345678 -> out_lteq=1; out_seq increments 1 then 2.
- SETTLE_CYCLES=4, out_ready held low 5 cycles after out_valid -> out_valid rises 4 edges after b handshake; out_valid/out_lteq/cmp_x stable; in_ready=0 throughout; result taken on the first out_ready=1 edge.
- rst_n pulled low for one edge while in S_EVAL -> next cycle: state S_A, out_valid=0, cmp_x=0, out_seq=0; no result emitted for the aborted pair.
- SEQ_W=2, five back-to-back comparisons -> out_seq sequence 0,1,2,3,0.
- CMP_SELF_CHECK_EN defined, cmp_y forced to 0 for a=0x00000005, b=0x00000005 -> chk_err=1 and stays 1 across later correct comparisons until reset.
